hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. Tracks destination registers of in-flight instructions and drives the select codes of the two EX-stage 3-input operand muxes (forwarding). Generates PC/IF-ID write enables, ID/EX bubble insertion and IF/ID flush. Freezes the whole pipeline while data memory is not ready, and counts stall cycles.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/forward_unit.sv | 21 ++
 rtl/hazard_ctrl.sv | 99 +++++++++
 tb/tb_hazard_ctrl.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Writer-only view used by the MEM and WB scoreboard slots
  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       rw;
  } wslot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_slot_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID/MEM status in, forwarding and pipeline control out
interface hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        if_id_flush;
  logic        pipe_hold;
  logic [31:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
           branch_taken, dmem_req, dmem_ready,
    input  fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_bubble,
           if_id_flush, pipe_hold, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read,
           branch_taken, dmem_req, dmem_ready,
    output fwd_a_sel, fwd_b_sel, pc_write, if_id_write, id_ex_bubble,
           if_id_flush, pipe_hold, stall_cycles
  );
endinterface

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX operand forwarding select for one source register
module forward_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  wslot_t     mem,
  input  wslot_t     wb,
  output fwd_sel_t   sel
);

  // MEM holds the younger result, so it wins over WB
  always_comb begin
    sel = FWD_REG;
    if (mem.valid && mem.rw && (mem.dst != REG_ZERO) && (mem.dst == src)) begin
      sel = FWD_MEM;
    end else if (wb.valid && wb.rw && (wb.dst != REG_ZERO) && (wb.dst == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use stall, branch flush and memory-wait freeze
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  ctrl_state_t state;
  ctrl_state_t state_next;
  ex_slot_t    ex_q;
  wslot_t      mem_q;
  wslot_t      wb_q;
  logic [31:0] stall_q;
  fwd_sel_t    fwd_a;
  fwd_sel_t    fwd_b;
  logic        load_use;
  logic        hold;
  logic        pcw;
  logic        ifw;
  logic        bub;
  logic        flush;

  forward_unit u_fwd_a (.src(ex_q.rs), .mem(mem_q), .wb(wb_q), .sel(fwd_a));
  forward_unit u_fwd_b (.src(ex_q.rt), .mem(mem_q), .wb(wb_q), .sel(fwd_b));

  assign load_use = bus.id_valid && ex_q.valid && ex_q.mr && (ex_q.dst != REG_ZERO) &&
                    ((ex_q.dst == bus.id_rs) || (ex_q.dst == bus.id_rt));

  always_comb begin
    state_next = state;
    hold       = 1'b0;
    pcw        = 1'b1;
    ifw        = 1'b1;
    bub        = 1'b0;
    flush      = 1'b0;
    case (state)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ready) begin
          state_next = MEM_WAIT;
          hold       = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_ready) state_next = RUN;
        else                hold       = 1'b1;
      end
    endcase
    // Priority: reset > memory wait > load-use > branch flush
    if (rst) begin
      state_next = RUN;
      hold       = 1'b0;
      pcw        = 1'b0;
      ifw        = 1'b0;
      bub        = 1'b1;
      flush      = 1'b1;
    end else if (hold) begin
      pcw = 1'b0;
      ifw = 1'b0;
    end else if (load_use) begin
      pcw = 1'b0;
      ifw = 1'b0;
      bub = 1'b1;
    end else begin
      flush = bus.branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
    end else begin
      state <= state_next;
      if (!pcw && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (!hold) begin
        wb_q  <= mem_q;
        mem_q <= '{valid: ex_q.valid, dst: ex_q.dst, rw: ex_q.rw};
        if (bub) ex_q <= '0;
        else     ex_q <= '{valid: bus.id_valid, dst: bus.id_dst, rw: bus.id_reg_write,
                           mr: bus.id_mem_read, rs: bus.id_rs, rt: bus.id_rt};
      end
    end
  end

  assign bus.fwd_a_sel    = rst ? FWD_REG : fwd_a;
  assign bus.fwd_b_sel    = rst ? FWD_REG : fwd_b;
  assign bus.pc_write     = pcw;
  assign bus.if_id_write  = ifw;
  assign bus.id_ex_bubble = bub;
  assign bus.if_id_flush  = flush;
  assign bus.pipe_hold    = hold;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();
  hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    bit       v;
    bit [4:0] dst;
    bit       rw;
    bit       mr;
    bit [4:0] rs;
    bit [4:0] rt;
  } ins_t;

  typedef struct {
    int          cyc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        pcw;
    logic        ifw;
    logic        bub;
    logic        fl;
    logic        hold;
    logic [31:0] sc;
  } exp_t;

  localparam ins_t EMPTY = '{v: 1'b0, dst: 5'd0, rw: 1'b0, mr: 1'b0, rs: 5'd0, rt: 5'd0};

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB
  ins_t        pipe [3];
  bit          waiting;
  bit   [31:0] count;
  exp_t        expq [$];
  int          total = 0;
  int          bad = 0;

  function automatic bit [1:0] model_fwd(bit [4:0] src);
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].v && pipe[s].rw && pipe[s].dst != 0 && pipe[s].dst == src)
        return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, want);
    end
  endtask

  // Monitor: the DUT presents a full set of outputs every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("fwd_a_sel",    e.cyc, {30'd0, bus.fwd_a_sel}, {30'd0, e.fa});
        chk("fwd_b_sel",    e.cyc, {30'd0, bus.fwd_b_sel}, {30'd0, e.fb});
        chk("pc_write",     e.cyc, {31'd0, bus.pc_write},  {31'd0, e.pcw});
        chk("if_id_write",  e.cyc, {31'd0, bus.if_id_write}, {31'd0, e.ifw});
        chk("id_ex_bubble", e.cyc, {31'd0, bus.id_ex_bubble}, {31'd0, e.bub});
        chk("if_id_flush",  e.cyc, {31'd0, bus.if_id_flush}, {31'd0, e.fl});
        chk("pipe_hold",    e.cyc, {31'd0, bus.pipe_hold}, {31'd0, e.hold});
        chk("stall_cycles", e.cyc, bus.stall_cycles, e.sc);
      end
    end
  end

  initial begin
    exp_t e;
    bit   r, idv, rw, mr, br, req, rdy, hold, lu;
    bit [4:0] rs, rt, dst;

    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_dst = '0;
    bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.branch_taken = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
    for (int s = 0; s < 3; s++) pipe[s] = EMPTY;
    waiting = 1'b0;
    count   = 32'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      r   = (i < 2) || ($urandom % 97 == 0) || (waiting && ($urandom % 6 == 0));
      idv = ($urandom % 10) != 0;
      rs  = 5'($urandom % 4);
      rt  = 5'($urandom % 4);
      dst = 5'($urandom % 4);
      rw  = ($urandom % 4) != 0;
      mr  = ($urandom % 3) == 0;
      br  = ($urandom % 5) == 0;
      req = ($urandom % 3) == 0;
      rdy = ($urandom % 3) != 0;

      rst = r;
      bus.id_valid = idv; bus.id_rs = rs; bus.id_rt = rt; bus.id_dst = dst;
      bus.id_reg_write = rw; bus.id_mem_read = mr; bus.branch_taken = br;
      bus.dmem_req = req; bus.dmem_ready = rdy;

      e.cyc = i;
      e.sc  = count;
      hold  = !r && (waiting ? !rdy : (req && !rdy));
      lu    = idv && pipe[0].v && pipe[0].mr && pipe[0].dst != 0 &&
              (pipe[0].dst == rs || pipe[0].dst == rt);
      if (r) begin
        e.fa = 2'b00; e.fb = 2'b00;
        e.pcw = 0; e.ifw = 0; e.bub = 1; e.fl = 1; e.hold = 0;
      end else begin
        e.fa = model_fwd(pipe[0].rs);
        e.fb = model_fwd(pipe[0].rt);
        e.hold = hold;
        if (hold) begin
          e.pcw = 0; e.ifw = 0; e.bub = 0; e.fl = 0;
        end else if (lu) begin
          e.pcw = 0; e.ifw = 0; e.bub = 1; e.fl = 0;
        end else begin
          e.pcw = 1; e.ifw = 1; e.bub = 0; e.fl = br;
        end
      end
      expq.push_back(e);

      if (r) begin
        for (int s = 0; s < 3; s++) pipe[s] = EMPTY;
        waiting = 1'b0;
        count   = 32'd0;
      end else begin
        if (!e.pcw && count != 32'hFFFF_FFFF) count = count + 1;
        if (!hold) begin
          pipe[2] = pipe[1];
          pipe[1] = pipe[0];
          pipe[0] = lu ? EMPTY : '{v: idv, dst: dst, rw: rw, mr: mr, rs: rs, rt: rt};
        end
        waiting = waiting ? !rdy : (req && !rdy);
      end
    end

    for (int k = 0; k < 5 && expq.size() > 0; k++) @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
